// File: rtl/hack_pc.sv
// Hack program counter: 16-bit PC with reset/load/increment priority and a
// registered wrap pulse. Next-state select is a chain of per-bit gate muxes.

module hack_pc_mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = (a & ~s) | (b & s);
endmodule

module hack_pc #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             rst_sync,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] inc_v, inc_sel, load_sel;

  assign inc_v = out_q + {{(WIDTH-1){1'b0}}, 1'b1};

  // Lowest priority first: inc over hold, load over that, rst_sync over all.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    hack_pc_mux2 u_inc  (.a(out_q[b]),    .b(inc_v[b]),     .s(inc),      .y(inc_sel[b]));
    hack_pc_mux2 u_load (.a(inc_sel[b]),  .b(in[b]),        .s(load),     .y(load_sel[b]));
    hack_pc_mux2 u_rst  (.a(load_sel[b]), .b(RESET_VEC[b]), .s(rst_sync), .y(out_d[b]));
  end

  assign wrap_d = ~rst_sync & ~load & inc & (&out_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= RESET_VEC;
      wrap_q <= 1'b0;
    end else if (ce) begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_hack_pc.sv
// Directed bench for hack_pc: reset, priority, wrap, clock enable, hold.

module tb_hack_pc;
  logic        clk = 1'b0;
  logic        reset, ce, rst_sync, load, inc;
  logic [15:0] in;
  logic [15:0] out;
  logic        wrap;
  int          total = 0;
  int          bad   = 0;

  hack_pc #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .reset(reset), .ce(ce), .rst_sync(rst_sync), .load(load),
    .inc(inc), .in(in), .out(out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic c, input logic r, input logic l, input logic i, input logic [15:0] d);
    ce = c; rst_sync = r; load = l; inc = i; in = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; ctl(1, 0, 0, 1, 16'h0000);
    #2;
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h exp=0000", out); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    step(); step();
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL reset_held got=%h exp=0000", out); end
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    ctl(1, 0, 1, 0, 16'h0122); step();
    ctl(1, 0, 0, 1, 16'h0000); step();
    total++; if (out !== 16'h0123) begin bad++; $display("FAIL areset_pre got=%h exp=0123", out); end
    #2 reset = 1'b1;
    #1;
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL areset_async got=%h exp=0000", out); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL areset_wrap got=%b exp=0", wrap); end
    step();
    reset = 1'b0;
    step(); step(); step();
    total++; if (out !== 16'h0003) begin bad++; $display("FAIL areset_release got=%h exp=0003", out); end
  endtask

  task automatic test_priority();
    ctl(1, 0, 1, 1, 16'h1234); step();
    total++; if (out !== 16'h1234) begin bad++; $display("FAIL prio_load_inc got=%h exp=1234", out); end
    ctl(1, 1, 1, 1, 16'h1234); step();
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL prio_rst_load got=%h exp=0000", out); end
  endtask

  task automatic test_wrap();
    ctl(1, 0, 1, 0, 16'hFFFE); step();
    ctl(1, 0, 0, 1, 16'h0000); step();
    total++; if (out !== 16'hFFFF || wrap !== 1'b0) begin bad++; $display("FAIL wrap_ffff got=%h/%b exp=ffff/0", out, wrap); end
    step();
    total++; if (out !== 16'h0000 || wrap !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%h/%b exp=0000/1", out, wrap); end
    step();
    total++; if (out !== 16'h0001 || wrap !== 1'b0) begin bad++; $display("FAIL wrap_after got=%h/%b exp=0001/0", out, wrap); end
    // load all-ones (with inc set) from all-ones must not pulse wrap
    ctl(1, 0, 1, 0, 16'hFFFF); step();
    ctl(1, 0, 1, 1, 16'hFFFF); step();
    total++; if (out !== 16'hFFFF || wrap !== 1'b0) begin bad++; $display("FAIL wrap_load_ones got=%h/%b exp=ffff/0", out, wrap); end
    ctl(1, 1, 0, 1, 16'h0000); step();
    total++; if (out !== 16'h0000 || wrap !== 1'b0) begin bad++; $display("FAIL wrap_rst_sync got=%h/%b exp=0000/0", out, wrap); end
  endtask

  task automatic test_ce();
    logic [15:0] exp_out;
    logic        exp_wrap;
    ctl(1, 0, 1, 0, 16'hFFFF); step();
    exp_out = 16'hFFFF; exp_wrap = 1'b0;
    for (int c = 0; c < 16; c++) begin
      ctl((c % 4) == 0, 0, 0, 1, 16'h0000);
      step();
      if ((c % 4) == 0) begin
        exp_wrap = (exp_out == 16'hFFFF);
        exp_out  = exp_out + 16'h0001;
      end
      total++;
      if (out !== exp_out || wrap !== exp_wrap) begin
        bad++; $display("FAIL ce_cycle%0d got=%h/%b exp=%h/%b", c, out, wrap, exp_out, exp_wrap);
      end
    end
    total++; if (out !== 16'h0003) begin bad++; $display("FAIL ce_advance got=%h exp=0003", out); end
  endtask

  task automatic test_hold();
    ctl(1, 0, 1, 0, 16'h00AA); step();
    ctl(1, 0, 0, 0, 16'h5A5A);
    for (int k = 0; k < 10; k++) step();
    total++; if (out !== 16'h00AA || wrap !== 1'b0) begin bad++; $display("FAIL hold got=%h/%b exp=00aa/0", out, wrap); end
  endtask

  task automatic test_reset_mid_load();
    ctl(1, 0, 1, 0, 16'h5555);
    #2 reset = 1'b1;
    #1;
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL midload_async got=%h exp=0000", out); end
    step();
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL midload_edge got=%h exp=0000", out); end
    ctl(1, 0, 0, 0, 16'h5555);
    reset = 1'b0;
    step(); step();
    total++; if (out !== 16'h0000 || wrap !== 1'b0) begin bad++; $display("FAIL midload_release got=%h/%b exp=0000/0", out, wrap); end
  endtask

  task automatic test_back_to_back();
    ctl(1, 0, 1, 0, 16'h7FFF); step();
    ctl(1, 0, 0, 1, 16'h0000); step();
    total++; if (out !== 16'h8000 || wrap !== 1'b0) begin bad++; $display("FAIL b2b_carry got=%h/%b exp=8000/0", out, wrap); end
    ctl(1, 0, 1, 0, 16'h0F0F); step();
    ctl(1, 0, 1, 0, 16'hF0F0); step();
    total++; if (out !== 16'hF0F0) begin bad++; $display("FAIL b2b_load got=%h exp=f0f0", out); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_priority();
    test_wrap();
    test_ce();
    test_hold();
    test_reset_mid_load();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
